// File: rtl/msr_pkg.sv
// Shared definitions for the multimode shift register: mode encoding and its width.
package msr_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CNTUP = 3'b110,
    MODE_CNTDN = 3'b111
  } msr_mode_e;

endpackage

// File: rtl/msr_next_state.sv
// Combinational next-state and next-carry function for the multimode shift register.
module msr_next_state
  import msr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_c,
  input  msr_mode_e        i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_q,
  output logic             o_c
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    o_q = i_q;
    o_c = i_c;
    case (i_mode)
      MODE_HOLD: begin
        o_q = i_q;
        o_c = i_c;
      end
      MODE_LOAD: begin
        o_q = i_d;
        o_c = 1'b0;
      end
      MODE_SHL: begin
        o_q = {i_q[WIDTH-2:0], i_serial};
        o_c = i_q[WIDTH-1];
      end
      MODE_SHR: begin
        o_q = {i_serial, i_q[WIDTH-1:1]};
        o_c = i_q[0];
      end
      MODE_ROL: begin
        o_q = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_c = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_q = {i_q[0], i_q[WIDTH-1:1]};
        o_c = i_q[0];
      end
      // Carry flags the wrap: leaving all-ones upward or zero downward.
      MODE_CNTUP: begin
        o_q = i_q + ONE;
        o_c = (i_q == {WIDTH{1'b1}});
      end
      MODE_CNTDN: begin
        o_q = i_q - ONE;
        o_c = (i_q == '0);
      end
      default: begin
        o_q = i_q;
        o_c = i_c;
      end
    endcase
  end

endmodule

// File: rtl/multimode_shift_register.sv
// WIDTH-bit register with hold/load/shift/rotate/count modes, registered carry and status outputs.
module multimode_shift_register
  import msr_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic              clk_signal,
  input  logic              reset_signal,
  input  logic              enable,
  input  logic              sync_clear,
  input  logic [MODE_W-1:0] mode_select,
  input  logic [WIDTH-1:0]  d_input,
  input  logic              serial_in,
  output logic [WIDTH-1:0]  q_output,
  output logic [WIDTH-1:0]  qb_output,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              msb_output,
  output logic              lsb_output
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH-1:0] w_q_next;
  logic             w_c_next;

  msr_next_state #(
    .WIDTH(WIDTH)
  ) u_next (
    .i_q     (r_q),
    .i_c     (r_carry),
    .i_mode  (msr_mode_e'(mode_select)),
    .i_d     (d_input),
    .i_serial(serial_in),
    .o_q     (w_q_next),
    .o_c     (w_c_next)
  );

  // Priority: async reset, then sync clear, then enable, then the selected mode.
  always_ff @(posedge clk_signal or posedge reset_signal) begin
    if (reset_signal) begin
      r_q     <= RST_Q;
      r_carry <= 1'b0;
    end else if (sync_clear) begin
      r_q     <= RST_Q;
      r_carry <= 1'b0;
    end else if (enable) begin
      r_q     <= w_q_next;
      r_carry <= w_c_next;
    end
  end

  assign q_output   = r_q;
  assign qb_output  = ~r_q;
  assign carry_flag = r_carry;
  assign zero_flag  = (r_q == '0);
  assign msb_output = r_q[WIDTH-1];
  assign lsb_output = r_q[0];

endmodule

// File: tb/tb_multimode_shift_register.sv
// Directed-vector bench for multimode_shift_register (two instances: reset value 0x00 and 0x3C).
module tb_multimode_shift_register;

  logic       clk_signal = 1'b0;
  logic       reset_signal;
  logic       enable;
  logic       sync_clear;
  logic [2:0] mode_select;
  logic [7:0] d_input;
  logic       serial_in;

  logic [7:0] q0, qb0, q1, qb1;
  logic       c0, z0, m0, l0, c1, z1, m1, l1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_signal = ~clk_signal;

  multimode_shift_register #(.WIDTH(8), .RESET_VALUE(32'h00)) dut0 (
    .clk_signal  (clk_signal),
    .reset_signal(reset_signal),
    .enable      (enable),
    .sync_clear  (sync_clear),
    .mode_select (mode_select),
    .d_input     (d_input),
    .serial_in   (serial_in),
    .q_output    (q0),
    .qb_output   (qb0),
    .carry_flag  (c0),
    .zero_flag   (z0),
    .msb_output  (m0),
    .lsb_output  (l0)
  );

  multimode_shift_register #(.WIDTH(8), .RESET_VALUE(32'h3C)) dut1 (
    .clk_signal  (clk_signal),
    .reset_signal(reset_signal),
    .enable      (enable),
    .sync_clear  (sync_clear),
    .mode_select (mode_select),
    .d_input     (d_input),
    .serial_in   (serial_in),
    .q_output    (q1),
    .qb_output   (qb1),
    .carry_flag  (c1),
    .zero_flag   (z1),
    .msb_output  (m1),
    .lsb_output  (l1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_signal);
    #1;
  endtask

  task automatic chk_qc(input string tag, input logic [7:0] q_exp, input logic c_exp);
    chk({tag, ".q"}, {24'h0, q0}, {24'h0, q_exp});
    chk({tag, ".c"}, {31'h0, c0}, {31'h0, c_exp});
  endtask

  logic [7:0] exp_q;

  initial begin
    reset_signal = 1'b1;
    enable       = 1'b0;
    sync_clear   = 1'b0;
    mode_select  = 3'b000;
    d_input      = 8'h00;
    serial_in    = 1'b0;
    #3;
    chk("rst.q",    {24'h0, q0},  32'h00);
    chk("rst.qb",   {24'h0, qb0}, 32'hFF);
    chk("rst.c",    {31'h0, c0},  32'h0);
    chk("rst.z",    {31'h0, z0},  32'h1);
    chk("rst1.q",   {24'h0, q1},  32'h3C);
    chk("rst1.qb",  {24'h0, qb1}, 32'hC3);
    chk("rst1.z",   {31'h0, z1},  32'h0);
    step();
    reset_signal = 1'b0;

    // Load A5 then pulse async reset between edges.
    enable = 1'b1; mode_select = 3'b001; d_input = 8'hA5;
    step();
    chk_qc("ldA5", 8'hA5, 1'b0);
    chk("ldA5.msb", {31'h0, m0}, 32'h1);
    chk("ldA5.lsb", {31'h0, l0}, 32'h1);
    chk("ldA5.z",   {31'h0, z0}, 32'h0);
    mode_select = 3'b000;
    #2 reset_signal = 1'b1;
    #1;
    chk_qc("arst", 8'h00, 1'b0);
    chk("arst.qb", {24'h0, qb0}, 32'hFF);
    chk("arst.z",  {31'h0, z0},  32'h1);
    #1 reset_signal = 1'b0;

    // Load and shift.
    mode_select = 3'b001; d_input = 8'h81;
    step(); chk_qc("ld81", 8'h81, 1'b0);
    mode_select = 3'b010; serial_in = 1'b0;
    step(); chk_qc("shl", 8'h02, 1'b1);
    mode_select = 3'b011; serial_in = 1'b1;
    step(); chk_qc("shr", 8'h81, 1'b0);

    // HOLD keeps q and carry.
    mode_select = 3'b010; serial_in = 1'b0;
    step(); chk_qc("shl2", 8'h02, 1'b1);
    mode_select = 3'b000;
    step(); chk_qc("hold", 8'h02, 1'b1);

    // Rotate right a single bit all the way round.
    mode_select = 3'b001; d_input = 8'h01;
    step(); chk_qc("ld01", 8'h01, 1'b0);
    mode_select = 3'b101;
    exp_q = 8'h80;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_qc($sformatf("ror%0d", i), exp_q, (i == 0));
      exp_q = {1'b0, exp_q[7:1]};
    end
    mode_select = 3'b001; d_input = 8'h80;
    step();
    mode_select = 3'b100;
    step(); chk_qc("rol", 8'h01, 1'b1);

    // Count wrap up and down.
    mode_select = 3'b001; d_input = 8'hFE;
    step();
    mode_select = 3'b110;
    step(); chk_qc("up0", 8'hFF, 1'b0); chk("up0.z", {31'h0, z0}, 32'h0);
    step(); chk_qc("up1", 8'h00, 1'b1); chk("up1.z", {31'h0, z0}, 32'h1);
    step(); chk_qc("up2", 8'h01, 1'b0); chk("up2.z", {31'h0, z0}, 32'h0);
    mode_select = 3'b001; d_input = 8'h00;
    step(); chk_qc("ld00", 8'h00, 1'b0);
    mode_select = 3'b111;
    step(); chk_qc("dn", 8'hFF, 1'b1);
    chk("dn.qb", {24'h0, qb0}, 32'h00);

    // Enable low holds regardless of mode.
    mode_select = 3'b001; d_input = 8'h55;
    step();
    enable = 1'b0; mode_select = 3'b110;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_qc($sformatf("en0_%0d", i), 8'h55, 1'b0);
    end

    // Sync clear overrides enable low and mode.
    sync_clear = 1'b1; mode_select = 3'b001; d_input = 8'hAA;
    step();
    chk_qc("sclr", 8'h00, 1'b0);
    chk("sclr1.q", {24'h0, q1}, 32'h3C);
    sync_clear = 1'b0;

    // Reset mid-count.
    enable = 1'b1; mode_select = 3'b001; d_input = 8'h10;
    step();
    mode_select = 3'b110;
    step(); chk_qc("cnt11", 8'h11, 1'b0);
    step(); chk_qc("cnt12", 8'h12, 1'b0);
    reset_signal = 1'b1;
    #1 chk_qc("mrst0", 8'h00, 1'b0);
    step(); chk_qc("mrst1", 8'h00, 1'b0);
    step(); chk_qc("mrst2", 8'h00, 1'b0);
    reset_signal = 1'b0;
    step(); chk_qc("after", 8'h01, 1'b0);

    // Inputs are sampled only at the edge.
    mode_select = 3'b001; d_input = 8'h3F;
    #3 d_input = 8'hC0;
    step(); chk_qc("samp", 8'hC0, 1'b0);
    mode_select = 3'b000; d_input = 8'hFF;
    #4 d_input = 8'h00;
    step(); chk_qc("glitch", 8'hC0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
